// File: rtl/liteic_pkg.sv
// Purpose: shared AXI4-Lite widths, response codes, FSM state types and helpers for the liteic slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package liteic_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int AXI_RESP_WIDTH = 2;

    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    // Byte-lane merge: lanes with a set strobe take the new data, others keep the old word.
    function automatic logic [AXI_DATA_WIDTH-1:0] apply_wstrb(
        input logic [AXI_DATA_WIDTH-1:0] old_word,
        input logic [AXI_DATA_WIDTH-1:0] new_word,
        input logic [AXI_STRB_WIDTH-1:0] strb
    );
        logic [AXI_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/liteic_axil_regfile.sv
// Purpose: AXI4-Lite responder exposing NUM_REGS byte-strobed 32-bit control registers; SLVERR outside the bank.
// Latency: B one cycle after the later of AW/W handshake; R one cycle after AR; regs_o updates on the commit edge.
// Backpressure: one write and one read outstanding; B/R held stable until bready/rready, readies low meanwhile.
//
// Ports:
//   aclk_i, aresetn_i            clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*              AXI4-Lite write address, data and response channels
//   s_ar*/s_r*                   AXI4-Lite read address and data channels
//   regs_o                       flattened register bank, reg k at [32k+31:32k]
module liteic_axil_regfile
    import liteic_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] REGION_SIZE = 32'h0010_0000,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                        aclk_i,
    input  logic                        aresetn_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr_i,
    input  logic                        s_awvalid_i,
    output logic                        s_awready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [AXI_STRB_WIDTH-1:0]   s_wstrb_i,
    input  logic                        s_wvalid_i,
    output logic                        s_wready_o,
    output logic [AXI_RESP_WIDTH-1:0]   s_bresp_o,
    output logic                        s_bvalid_o,
    input  logic                        s_bready_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr_i,
    input  logic                        s_arvalid_i,
    output logic                        s_arready_o,
    output logic [AXI_DATA_WIDTH-1:0]   s_rdata_o,
    output logic [AXI_RESP_WIDTH-1:0]   s_rresp_o,
    output logic                        s_rvalid_o,
    input  logic                        s_rready_i,
    output logic [NUM_REGS*32-1:0]      regs_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Offset within the slot; byte lanes [1:0] are ignored, anything past the bank is a miss.
    function automatic dec_t decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] offset;
        dec_t                      d;
        offset = addr & (REGION_SIZE - 32'd1);
        d.hit  = (offset < AXI_ADDR_WIDTH'(NUM_REGS * 4));
        d.idx  = offset[2 +: IDX_W];
        return d;
    endfunction

    logic                                    r_en;
    logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] r_regs;

    wr_state_t                  r_wr_state;
    wr_state_t                  w_wr_next;
    logic [AXI_ADDR_WIDTH-1:0]  r_awaddr;
    logic [AXI_DATA_WIDTH-1:0]  r_wdata;
    logic [AXI_STRB_WIDTH-1:0]  r_wstrb;
    logic [AXI_RESP_WIDTH-1:0]  r_bresp;

    rd_state_t                  r_rd_state;
    rd_state_t                  w_rd_next;
    logic [AXI_DATA_WIDTH-1:0]  r_rdata;
    logic [AXI_RESP_WIDTH-1:0]  r_rresp;

    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_ar_hs;
    logic                       w_commit;
    logic [AXI_ADDR_WIDTH-1:0]  w_wr_addr;
    logic [AXI_DATA_WIDTH-1:0]  w_wr_data;
    logic [AXI_STRB_WIDTH-1:0]  w_wr_strb;
    dec_t                       w_wr_dec;
    dec_t                       w_rd_dec;

    // Readies are pure state decodes, gated by r_en so they stay low through the reset cycle.
    assign s_awready_o = r_en && ((r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_W));
    assign s_wready_o  = r_en && ((r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_AW));
    assign s_bvalid_o  = (r_wr_state == WR_RESP);
    assign s_bresp_o   = r_bresp;
    assign s_arready_o = r_en && (r_rd_state == RD_IDLE);
    assign s_rvalid_o  = (r_rd_state == RD_RESP);
    assign s_rdata_o   = r_rdata;
    assign s_rresp_o   = r_rresp;
    assign regs_o      = r_regs;

    assign w_aw_hs = s_awvalid_i && s_awready_o;
    assign w_w_hs  = s_wvalid_i  && s_wready_o;
    assign w_ar_hs = s_arvalid_i && s_arready_o;

    // Whichever half arrives in the commit cycle is taken straight from the bus.
    assign w_wr_addr = w_aw_hs ? s_awaddr_i : r_awaddr;
    assign w_wr_data = w_w_hs  ? s_wdata_i  : r_wdata;
    assign w_wr_strb = w_w_hs  ? s_wstrb_i  : r_wstrb;
    assign w_wr_dec  = decode(w_wr_addr);
    assign w_rd_dec  = decode(s_araddr_i);

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_en       <= 1'b0;
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_en       <= 1'b1;
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
        end
    end

    always_comb begin
        w_wr_next = r_wr_state;
        w_commit  = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit = 1'b1;
                end else if (w_aw_hs) begin
                    w_wr_next = WR_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: w_commit = w_w_hs;
            WR_HAVE_W:  w_commit = w_aw_hs;
            WR_RESP: begin
                if (s_bready_i) begin
                    w_wr_next = WR_IDLE;
                end
            end
            default: w_wr_next = WR_IDLE;
        endcase
        if (w_commit) begin
            w_wr_next = WR_RESP;
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_rready_i) begin
                    w_rd_next = RD_IDLE;
                end
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= AXI_RESP_OKAY;
            r_regs   <= {NUM_REGS{RESET_VALUE}};
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= s_awaddr_i;
            end
            if (w_w_hs) begin
                r_wdata <= s_wdata_i;
                r_wstrb <= s_wstrb_i;
            end
            if (w_commit) begin
                r_bresp <= w_wr_dec.hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                if (w_wr_dec.hit) begin
                    r_regs[w_wr_dec.idx] <= apply_wstrb(r_regs[w_wr_dec.idx], w_wr_data, w_wr_strb);
                end
            end
        end
    end

    // Captured from r_regs before this edge's write lands, so a coincident write returns the old value.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_rdata <= '0;
            r_rresp <= AXI_RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_dec.hit ? r_regs[w_rd_dec.idx] : '0;
            r_rresp <= w_rd_dec.hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_liteic_axil_regfile.sv
// Purpose: randomized and directed check of liteic_axil_regfile against a word-array model with response queues.
// Latency: n/a (testbench).
// Backpressure: bready/rready driven directly or randomly per phase.
module tb_liteic_axil_regfile;
    import liteic_pkg::*;

    localparam int NREG = 16;

    logic                      aclk_i;
    logic                      aresetn_i;
    logic [AXI_ADDR_WIDTH-1:0] s_awaddr_i;
    logic                      s_awvalid_i;
    logic                      s_awready_o;
    logic [AXI_DATA_WIDTH-1:0] s_wdata_i;
    logic [AXI_STRB_WIDTH-1:0] s_wstrb_i;
    logic                      s_wvalid_i;
    logic                      s_wready_o;
    logic [AXI_RESP_WIDTH-1:0] s_bresp_o;
    logic                      s_bvalid_o;
    logic                      s_bready_i;
    logic [AXI_ADDR_WIDTH-1:0] s_araddr_i;
    logic                      s_arvalid_i;
    logic                      s_arready_o;
    logic [AXI_DATA_WIDTH-1:0] s_rdata_o;
    logic [AXI_RESP_WIDTH-1:0] s_rresp_o;
    logic                      s_rvalid_o;
    logic                      s_rready_i;
    logic [NREG*32-1:0]        regs_o;

    liteic_axil_regfile #(
        .NUM_REGS    (NREG),
        .REGION_SIZE (32'h0010_0000),
        .RESET_VALUE (32'h0)
    ) dut (
        .aclk_i      (aclk_i),
        .aresetn_i   (aresetn_i),
        .s_awaddr_i  (s_awaddr_i),
        .s_awvalid_i (s_awvalid_i),
        .s_awready_o (s_awready_o),
        .s_wdata_i   (s_wdata_i),
        .s_wstrb_i   (s_wstrb_i),
        .s_wvalid_i  (s_wvalid_i),
        .s_wready_o  (s_wready_o),
        .s_bresp_o   (s_bresp_o),
        .s_bvalid_o  (s_bvalid_o),
        .s_bready_i  (s_bready_i),
        .s_araddr_i  (s_araddr_i),
        .s_arvalid_i (s_arvalid_i),
        .s_arready_o (s_arready_o),
        .s_rdata_o   (s_rdata_o),
        .s_rresp_o   (s_rresp_o),
        .s_rvalid_o  (s_rvalid_o),
        .s_rready_i  (s_rready_i),
        .regs_o      (regs_o)
    );

    initial begin
        aclk_i = 1'b0;
        forever #5 aclk_i = ~aclk_i;
    end

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model [NREG];
    logic [1:0]  b_q [$];
    logic [31:0] r_dat_q [$];
    logic [1:0]  r_resp_q [$];
    bit          rand_bp = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endfunction

    // Reference decode: 1 MiB slot, 16 words from offset 0.
    function automatic bit m_hit(input logic [31:0] a);
        return (a & 32'h000F_FFFF) < NREG * 4;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a & 32'h000F_FFFF) / 4);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NREG; k++) model[k] = 32'h0;
        b_q.delete();
        r_dat_q.delete();
        r_resp_q.delete();
    endfunction

    function automatic void check_regs(input string name);
        for (int k = 0; k < NREG; k++) check(name, regs_o[32*k +: 32], model[k]);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a[31:20] = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 3) != 0) a[19:0] = 20'($urandom_range(0, NREG - 1) * 4 + $urandom_range(0, 3));
        else                           a[19:0] = 20'($urandom_range(NREG * 4, 20'hF_FFFF));
        return a;
    endfunction

    // Scoreboard monitors: pop on each handshake seen mid-cycle.
    initial begin
        forever begin
            @(negedge aclk_i);
            if (aresetn_i && s_bvalid_o && s_bready_i) begin
                if (b_q.size() == 0) check("bresp_unexpected", {30'h0, s_bresp_o}, 32'hFFFF_FFFF);
                else                 check("bresp", {30'h0, s_bresp_o}, {30'h0, b_q.pop_front()});
            end
        end
    end

    initial begin
        forever begin
            @(negedge aclk_i);
            if (aresetn_i && s_rvalid_o && s_rready_i) begin
                if (r_dat_q.size() == 0) begin
                    check("rvalid_unexpected", {31'h0, s_rvalid_o}, 32'h0);
                end else begin
                    check("rdata", s_rdata_o, r_dat_q.pop_front());
                    check("rresp", {30'h0, s_rresp_o}, {30'h0, r_resp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk_i);
            #1;
            if (rand_bp) begin
                s_bready_i = 1'($urandom_range(0, 1));
                s_rready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit fa, fw;
        int c = 0;
        b_q.push_back(m_hit(addr) ? AXI_RESP_OKAY : AXI_RESP_SLVERR);
        while (!(aw_done && w_done) && c < 100) begin
            if (!aw_done && c == aw_dly) begin s_awvalid_i = 1'b1; s_awaddr_i = addr; end
            if (!w_done && c == w_dly) begin s_wvalid_i = 1'b1; s_wdata_i = data; s_wstrb_i = strb; end
            @(negedge aclk_i);
            if (!aw_done) check("awready_while_pending", {31'h0, s_awready_o}, 32'h1);
            if (!w_done)  check("wready_while_pending", {31'h0, s_wready_o}, 32'h1);
            fa = s_awvalid_i && s_awready_o;
            fw = s_wvalid_i && s_wready_o;
            @(posedge aclk_i);
            #1;
            if (fa) begin s_awvalid_i = 1'b0; aw_done = 1'b1; end
            if (fw) begin s_wvalid_i = 1'b0; w_done = 1'b1; end
            c++;
        end
        if (!(aw_done && w_done)) begin
            fail_now("write_handshake");
            s_awvalid_i = 1'b0;
            s_wvalid_i  = 1'b0;
            return;
        end
        if (m_hit(addr)) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[m_idx(addr)][8*b +: 8] = data[8*b +: 8];
        end
        check("bvalid_after_commit", {31'h0, s_bvalid_o}, 32'h1);
        check("awready_in_resp", {31'h0, s_awready_o}, 32'h0);
        check("wready_in_resp", {31'h0, s_wready_o}, 32'h0);
        check_regs("regs_after_commit");
    endtask

    task automatic axi_read(input logic [31:0] addr, input int dly);
        bit fa = 1'b0;
        int c  = 0;
        r_dat_q.push_back(m_hit(addr) ? model[m_idx(addr)] : 32'h0);
        r_resp_q.push_back(m_hit(addr) ? AXI_RESP_OKAY : AXI_RESP_SLVERR);
        repeat (dly) begin @(posedge aclk_i); #1; end
        s_arvalid_i = 1'b1;
        s_araddr_i  = addr;
        while (!fa && c < 100) begin
            @(negedge aclk_i);
            fa = s_arvalid_i && s_arready_o;
            @(posedge aclk_i);
            #1;
            c++;
        end
        s_arvalid_i = 1'b0;
        if (!fa) begin
            fail_now("read_handshake");
            return;
        end
        check("rvalid_after_ar", {31'h0, s_rvalid_o}, 32'h1);
        check("arready_in_resp", {31'h0, s_arready_o}, 32'h0);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((b_q.size() != 0 || r_dat_q.size() != 0) && c < 400) begin
            @(posedge aclk_i);
            c++;
        end
        if (b_q.size() != 0 || r_dat_q.size() != 0) begin
            fail_now("response_drain");
            b_q.delete();
            r_dat_q.delete();
            r_resp_q.delete();
        end
        @(posedge aclk_i);
        #1;
    endtask

    task automatic check_readies(input string name, input logic [31:0] exp);
        check({name, "_awready"}, {31'h0, s_awready_o}, exp);
        check({name, "_wready"},  {31'h0, s_wready_o},  exp);
        check({name, "_arready"}, {31'h0, s_arready_o}, exp);
    endtask

    initial begin
        logic [31:0] wa, ra, wd;
        logic [3:0]  ws;
        int          op, d0, d1;

        aresetn_i   = 1'b0;
        s_awaddr_i  = '0; s_awvalid_i = 1'b0;
        s_wdata_i   = '0; s_wstrb_i   = '0; s_wvalid_i = 1'b0;
        s_araddr_i  = '0; s_arvalid_i = 1'b0;
        s_bready_i  = 1'b1; s_rready_i = 1'b1;
        model_reset();

        // Reset state.
        repeat (3) @(posedge aclk_i);
        @(negedge aclk_i);
        check_readies("reset", 32'h0);
        check("reset_bvalid", {31'h0, s_bvalid_o}, 32'h0);
        check("reset_rvalid", {31'h0, s_rvalid_o}, 32'h0);
        check("reset_bresp", {30'h0, s_bresp_o}, 32'h0);
        check("reset_rresp", {30'h0, s_rresp_o}, 32'h0);
        check("reset_rdata", s_rdata_o, 32'h0);
        check_regs("reset_regs");
        @(posedge aclk_i); #1;
        aresetn_i = 1'b1;
        @(negedge aclk_i);
        check_readies("first_cycle", 32'h0);
        @(posedge aclk_i); #1;
        check_readies("enabled", 32'h1);

        // Write commit to reg 1 coincident with AR of reg 1: read sees the old value.
        fork
            axi_write(32'h0000_0004, 32'hAAAA_5555, 4'hF, 0, 0);
            axi_read(32'h0000_0004, 0);
        join
        wait_idle();
        axi_read(32'h0000_0004, 0);
        wait_idle();

        // W first, AW three cycles later, partial strobes over zero.
        axi_write(32'h0000_0008, 32'h1122_3344, 4'b0101, 3, 0);
        check("reg2_strobe", regs_o[95:64], 32'h0022_0044);
        wait_idle();

        // Same-cycle AW+W then readback.
        axi_write(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
        check("reg1_full", regs_o[63:32], 32'hDEAD_BEEF);
        wait_idle();
        axi_read(32'h0000_0004, 0);
        wait_idle();

        // AW before W, zero strobes, and out-of-bank accesses.
        axi_write(32'h0000_003C, 32'h0BAD_F00D, 4'hC, 0, 2);
        wait_idle();
        axi_write(32'h0000_0004, 32'h1234_5678, 4'h0, 0, 0);
        wait_idle();
        axi_write(32'h0000_0040, 32'h1234_5678, 4'hF, 0, 0);
        wait_idle();
        axi_read(32'h0000_0040, 0);
        wait_idle();
        axi_read(32'h0010_003F, 1);
        wait_idle();

        // rready held low: response must hold still, no new AR accepted.
        s_rready_i = 1'b0;
        axi_read(32'h0000_0008, 0);
        repeat (5) begin
            @(negedge aclk_i);
            check("hold_rvalid", {31'h0, s_rvalid_o}, 32'h1);
            check("hold_rdata", s_rdata_o, 32'h0022_0044);
            check("hold_arready", {31'h0, s_arready_o}, 32'h0);
        end
        @(posedge aclk_i); #1;
        s_rready_i = 1'b1;
        @(posedge aclk_i); #1;
        check("arready_after_r", {31'h0, s_arready_o}, 32'h1);
        check("rvalid_after_r", {31'h0, s_rvalid_o}, 32'h0);
        wait_idle();

        // Randomized traffic with random response backpressure.
        rand_bp = 1'b1;
        for (int t = 0; t < 150; t++) begin
            op = $urandom_range(0, 2);
            wa = rand_addr();
            ra = rand_addr();
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            d0 = $urandom_range(0, 3);
            d1 = $urandom_range(0, 3);
            if (op == 2 && m_hit(wa) && m_hit(ra) && m_idx(wa) == m_idx(ra)) op = 0;
            case (op)
                0: axi_write(wa, wd, ws, d0, d1);
                1: axi_read(ra, d0);
                default: fork
                    axi_write(wa, wd, ws, d0, d1);
                    axi_read(ra, d1);
                join
            endcase
            wait_idle();
        end
        rand_bp = 1'b0;
        @(posedge aclk_i); #2;
        s_bready_i = 1'b1;
        s_rready_i = 1'b1;
        wait_idle();

        // Reset while a write response is pending.
        s_bready_i = 1'b0;
        axi_write(32'h0000_000C, 32'h5A5A_5A5A, 4'hF, 0, 0);
        @(negedge aclk_i);
        check("pre_reset_bvalid", {31'h0, s_bvalid_o}, 32'h1);
        aresetn_i = 1'b0;
        #1;
        model_reset();
        check("reset_drops_bvalid", {31'h0, s_bvalid_o}, 32'h0);
        check("reset_drops_bresp", {30'h0, s_bresp_o}, 32'h0);
        check_readies("in_reset", 32'h0);
        check_regs("mid_reset_regs");
        @(posedge aclk_i); #1;
        aresetn_i  = 1'b1;
        s_bready_i = 1'b1;
        @(negedge aclk_i);
        check_readies("release_cycle", 32'h0);
        @(posedge aclk_i); #1;
        check_readies("release_next", 32'h1);

        // Reset while only AW is held: the captured address must be forgotten.
        s_awaddr_i  = 32'h0000_0010;
        s_awvalid_i = 1'b1;
        @(posedge aclk_i); #1;
        s_awvalid_i = 1'b0;
        check("have_aw_awready", {31'h0, s_awready_o}, 32'h0);
        check("have_aw_wready", {31'h0, s_wready_o}, 32'h1);
        @(negedge aclk_i);
        aresetn_i = 1'b0;
        #1;
        check_readies("aw_reset", 32'h0);
        @(posedge aclk_i); #1;
        aresetn_i = 1'b1;
        @(posedge aclk_i); #1;
        check_readies("aw_release", 32'h1);
        s_wdata_i  = 32'hFFFF_FFFF;
        s_wstrb_i  = 4'hF;
        s_wvalid_i = 1'b1;
        @(posedge aclk_i); #1;
        s_wvalid_i = 1'b0;
        repeat (4) begin
            @(negedge aclk_i);
            check("lone_w_no_bvalid", {31'h0, s_bvalid_o}, 32'h0);
        end
        check("lone_w_awready", {31'h0, s_awready_o}, 32'h1);
        check("lone_w_wready", {31'h0, s_wready_o}, 32'h0);
        check_regs("lone_w_regs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
